// File: rtl/clk_div_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chain_pkg
// Description : Shared constants for the divide-by-2 chain and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_chain_pkg;

    // Width of the divided-clock vector, also used by the mask/output stage
    localparam int SIG_GEN_WIDTH = 8;

endpackage : clk_div_chain_pkg
`default_nettype wire

// File: rtl/clk_div_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chain_if
// Description : Carries the divided clock vector from the chain to its users.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_chain_if
    import clk_div_chain_pkg::*;
#(
    parameter int WIDTH = SIG_GEN_WIDTH
);

    logic [WIDTH-1:0] signal_gen_out;

    modport master (output signal_gen_out);
    modport slave  (input  signal_gen_out);

endinterface : clk_div_chain_if
`default_nettype wire

// File: rtl/clk_div_chain_toggle_stage.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chain_toggle_stage
// Description : Single T flip-flop with asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chain_toggle_stage (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic t,
    output logic      q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule : clk_div_chain_toggle_stage
`default_nettype wire

// File: rtl/clk_div_chain.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chain
// Description : Free-running synchronous counter; bit k is clk/2^(k+1), 50% duty.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chain
    import clk_div_chain_pkg::*;
#(
    parameter int WIDTH = SIG_GEN_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    clk_div_chain_if.master    sig
);

    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_carry;

    // Carry chain: stage k toggles only when every lower stage is 1, so all
    // stages share one clock edge and the outputs come straight off flops.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar k = 0; k < WIDTH; k++) begin : g_stage
            if (k > 0) begin : g_carry
                assign w_carry[k] = w_carry[k-1] & w_cnt[k-1];
            end

            clk_div_chain_toggle_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .t     (w_carry[k]),
                .q     (w_cnt[k])
            );
        end
    endgenerate

    assign sig.signal_gen_out = w_cnt;

endmodule : clk_div_chain
`default_nettype wire

// File: tb/tb_clk_div_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_chain
// Description : Directed vector bench for the divide-by-2 chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_chain;

    typedef struct {
        int         edges;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    clk_div_chain_if #(.WIDTH(8)) sig_if ();

    clk_div_chain #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if ($isunknown(act) || act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[7];
        int         edges;
        logic [7:0] model;
        logic [7:0] prev;
        logic [7:0] cur;
        int         rises[8];
        int         highs[8];
        int         first_rise[8];
        int         run[8];
        int         max_run[8];
        int         probe[3];

        checks   = 0;
        failures = 0;
        vecs[0] = '{1,   8'h01};
        vecs[1] = '{2,   8'h02};
        vecs[2] = '{3,   8'h03};
        vecs[3] = '{128, 8'h80};
        vecs[4] = '{255, 8'hFF};
        vecs[5] = '{256, 8'h00};
        vecs[6] = '{257, 8'h01};
        probe[0] = 0;
        probe[1] = 3;
        probe[2] = 7;

        // Asynchronous assertion between edges, then hold for 3 cycles
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", sig_if.signal_gen_out, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", sig_if.signal_gen_out, 8'h00);
        end

        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 7; i++) begin
            while (edges < vecs[i].edges) begin
                step();
                edges++;
            end
            check($sformatf("vec_edge%0d", vecs[i].edges), sig_if.signal_gen_out, vecs[i].exp);
        end

        // Per-cycle reference model and waveform statistics over 512 cycles
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_again", sig_if.signal_gen_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model = 8'h00;
        prev  = 8'h00;
        for (int b = 0; b < 8; b++) begin
            rises[b] = 0; highs[b] = 0; first_rise[b] = -1; run[b] = 0; max_run[b] = 0;
        end
        for (int n = 1; n <= 512; n++) begin
            step();
            model = model + 8'h01;
            cur   = sig_if.signal_gen_out;
            check($sformatf("model_edge%0d", n), cur, model);
            for (int b = 0; b < 8; b++) begin
                if (cur[b] === 1'b1) begin
                    highs[b]++;
                    run[b]++;
                    if (run[b] > max_run[b]) max_run[b] = run[b];
                    if (prev[b] !== 1'b1) begin
                        rises[b]++;
                        if (first_rise[b] < 0) first_rise[b] = n;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            prev = cur;
        end
        for (int p = 0; p < 3; p++) begin
            automatic int k = probe[p];
            check_int($sformatf("bit%0d_rises", k),      rises[k],      512 >> (k + 1));
            check_int($sformatf("bit%0d_high_total", k), highs[k],      256);
            check_int($sformatf("bit%0d_high_run", k),   max_run[k],    1 << k);
            check_int($sformatf("bit%0d_first_rise", k), first_rise[k], 1 << k);
        end

        // Mid-count asynchronous reset at 0x5A
        for (int n = 0; n < 90; n++) step();
        check("pre_midreset", sig_if.signal_gen_out, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", sig_if.signal_gen_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midreset_resume", sig_if.signal_gen_out, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_div_chain
`default_nettype wire
